// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register word map,
// default source count and VEC layout.
package irq_pkg;

  localparam int N_SRC_DEFAULT = 6;

  localparam logic [2:0] IRQ_PEND = 3'd0;
  localparam logic [2:0] IRQ_MASK = 3'd1;
  localparam logic [2:0] IRQ_MODE = 3'd2;
  localparam logic [2:0] IRQ_ISR  = 3'd3;
  localparam logic [2:0] IRQ_VEC  = 3'd4;

  localparam int VEC_VALID_BIT = 31;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder; idx reads W when no bit is set.
module irq_prio_enc #(
  parameter int W     = 6,
  parameter int IDX_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     vec,
  output logic [W-1:0]     oneHot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scanning downward leaves the lowest set bit as the final winner.
  always_comb begin
    oneHot = '0;
    idx    = IDX_W'(W);
    valid  = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        oneHot    = '0;
        oneHot[i] = 1'b1;
        idx       = IDX_W'(i);
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Programmable interrupt controller feeding CP0 hwInt: pending/mask/mode
// registers, in-service tracking for strict-priority nesting, bridge reg file.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic [2:0]       addr,
  input  logic             we,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic             taken,
  output logic [N_SRC-1:0] hwInt
);

  localparam int IDX_W = $clog2(N_SRC + 1);

  logic [N_SRC-1:0] srcQ, pend, mask, mode, isr;
  logic [N_SRC-1:0] kOneHot, belowK, eligible, selOneHot;
  logic [IDX_W-1:0] unusedKIdx, selIdx;
  logic             kValid, selValid;
  logic [N_SRC-1:0] pendSet, w1cClr, takenClr, eoiClr, takenSet;
  logic [N_SRC-1:0] pendNext, isrNext;
  logic             wrPend, wrMask, wrMode, wrIsr, takenHit;
  logic [31-N_SRC:0] unusedWdata;

  assign unusedWdata = wdata[31:N_SRC];

  irq_prio_enc #(.W(N_SRC), .IDX_W(IDX_W)) u_kEnc (
    .vec   (isr),
    .oneHot(kOneHot),
    .idx   (unusedKIdx),
    .valid (kValid)
  );

  // Only lines strictly above the highest-priority in-service line may nest.
  assign belowK   = kValid ? (kOneHot - N_SRC'(1)) : '1;
  assign eligible = pend & mask & belowK;

  irq_prio_enc #(.W(N_SRC), .IDX_W(IDX_W)) u_selEnc (
    .vec   (eligible),
    .oneHot(selOneHot),
    .idx   (selIdx),
    .valid (selValid)
  );

  assign wrPend   = we && (addr == IRQ_PEND);
  assign wrMask   = we && (addr == IRQ_MASK);
  assign wrMode   = we && (addr == IRQ_MODE);
  assign wrIsr    = we && (addr == IRQ_ISR);
  assign takenHit = taken && (|hwInt);

  assign pendSet  = (mode & src & ~srcQ) | (~mode & src);
  assign w1cClr   = wrPend ? wdata[N_SRC-1:0] : '0;
  // Level lines stay pending on acceptance; the ISR bit blocks them until EOI.
  assign takenClr = takenHit ? (hwInt & mode) : '0;
  assign takenSet = takenHit ? hwInt : '0;
  assign eoiClr   = wrIsr ? kOneHot : '0;

  assign pendNext = (pend & ~w1cClr & ~takenClr) | pendSet;
  assign isrNext  = (isr & ~eoiClr) | takenSet;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      srcQ  <= '0;
      pend  <= '0;
      mask  <= '0;
      mode  <= '0;
      isr   <= '0;
      hwInt <= '0;
    end else begin
      srcQ  <= src;
      pend  <= pendNext;
      isr   <= isrNext;
      hwInt <= selOneHot;
      if (wrMask) mask <= wdata[N_SRC-1:0];
      if (wrMode) mode <= wdata[N_SRC-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      IRQ_PEND: rdata[N_SRC-1:0] = pend;
      IRQ_MASK: rdata[N_SRC-1:0] = mask;
      IRQ_MODE: rdata[N_SRC-1:0] = mode;
      IRQ_ISR:  rdata[N_SRC-1:0] = isr;
      IRQ_VEC: begin
        if (selValid) begin
          rdata[VEC_VALID_BIT] = 1'b1;
          rdata[IDX_W-1:0]     = selIdx;
        end
      end
      default: rdata = '0;
    endcase
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Programmable interrupt controller between the peripheral devices (timers, UART, bridge-attached I/O) and the CP0 `hwInt` inputs. It latches device interrupt lines as pending bits, applies per-line mask and edge/level mode, and presents exactly one line at a time to CP0. The line it presents is the highest-priority eligible one. It tracks in-service lines so that only strictly higher-priority interrupts can nest, and the handler reaches its registers through the system bridge.

## Interface
- `N_SRC`, 6: number of interrupt sources; equals CP0 `hwInt` width.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `src`  in  N_SRC  device interrupt lines, synchronous to `clk`.
- `addr`  in  3  bridge word address (byte address bits [4:2]).
- `we`  in  1  bridge write strobe, one cycle per write.
- `wdata`  in  32  bridge write data.
- `rdata`  out  32  bridge read data, combinational from `addr`.
- `taken`  in  1  one-cycle pulse from the CPU when CP0 accepts an interrupt (intReq path, not exceptions).
- `hwInt`  out  N_SRC  to CP0 `hwInt`; registered, at most one bit set.

## Operation
- Register map (word index: name):
  - 0: PEND. Read gives `pend`. Write is write-1-to-clear.
  - 1: MASK. R/W; a 1 enables the line.
  - 2: MODE. R/W; 1 = edge-triggered, 0 = level-triggered.
  - 3: ISR. Read gives `isr`. Any write is an EOI and `wdata` is ignored.
  - 4: VEC. Read-only: bit31 = valid, bits[2:0] = selected index, other bits 0.
  - 5–7: read 0, writes ignored.
- `src_q` holds `src` delayed by one cycle, for every line and every mode.
- Pending set:
  - Edge mode: set when `src & ~src_q`.
  - Level mode: set every cycle `src` is 1.
  - A set wins over a same-cycle W1C.
- Priority: a lower index has higher priority. `k` is the lowest set index of `isr`; if `isr` is 0, `k` is `N_SRC`.
- Eligible lines are `pend & mask` restricted to indices below `k`. `sel` is the lowest eligible index. `valid` means at least one line is eligible.
- `hwInt` is registered each cycle to the one-hot of `sel`, or 0 when nothing is eligible.
- When `taken` is 1 and `hwInt` is nonzero:
  - `isr |= hwInt`.
  - If the line is edge mode, its `pend` bit is cleared.
  - If the line is level mode, `pend` stays set and `isr` blocks it until EOI.
- When `taken` is 1 and `hwInt` is 0: ignored.
- EOI clears bit `k` of the pre-update `isr`. EOI with `isr` = 0 has no effect.
- EOI and `taken` in the same cycle: the EOI clear uses the old `isr`, then the `taken` bit is ORed in.
- A write to MASK or MODE takes effect in the next cycle's `hwInt`. A line that is masked while presented drops from `hwInt` one cycle after the write.

## Timing
- Reset values: `pend`, `mask`, `mode`, `isr`, `src_q`, `hwInt` are all 0. `rdata` is 0 at address 0.
- Reset is asynchronous. Asserting it mid-service drops `hwInt` immediately and clears all in-service state.
- Latency, `src` rise to `hwInt`:
  - `src[i]` sampled 1 at edge E0, so `pend[i]` is 1 after E0.
  - `hwInt[i]` is 1 after E1, so latency is 2 cycles.
- Latency, `taken` to `hwInt` change: `taken` at edge E0 gives updated `isr` after E0 and updated `hwInt` after E1.
- Register writes are visible on `rdata` the cycle after `we`.
- `hwInt` never has more than one bit set, including during re-selection.

## Structure
- Shared package `irq_pkg`:
  - Register word indices (`IRQ_PEND` = 0 … `IRQ_VEC` = 4).
  - Default `N_SRC`.
  - `VEC_VALID_BIT` = 31.
- Sub-module `irq_prio_enc`: combinational lowest-index-first encoder returning one-hot, index and valid.
  - Instantiated twice: once for `sel` over the eligible vector, once for `k` over `isr`.

## Test plan
- Level line 3, MASK = 0x08, MODE = 0. Hold `src[3]` = 1 → `hwInt` = 0x08 two cycles later. Pulse `taken` → `hwInt` = 0x00, ISR = 0x08, PEND still 0x08. Write EOI → ISR = 0. `hwInt` = 0x08 again while `src[3]` stays high.
- Edge line 1, MASK = 0x02, MODE = 0x02. Pulse `src[1]` for one cycle → PEND = 0x02 and `hwInt` = 0x02. Pulse `taken` → PEND = 0, ISR = 0x02, `hwInt` = 0.
- Nesting: line 4 in service (ISR = 0x10). Raise edge line 2 → `hwInt` = 0x04. Raise line 5 instead → `hwInt` stays 0 until EOI, then becomes 0x20.
- Simultaneous: edge on line 0 in the same cycle as a W1C of 0x01 to PEND → PEND bit 0 remains 1. EOI in the same cycle as `taken` with ISR = 0x08 and `hwInt` = 0x02 → ISR = 0x02.
- VEC read with lines 2 and 4 pending and enabled → 0x8000_0002. With nothing eligible → 0x0000_0000. Reads of words 5–7 return 0.
- Assert `reset` while ISR = 0x04 and `hwInt` = 0x01 → all registers and `hwInt` are 0 immediately, with no clock edge required.
